// File: rtl/xadc_drp_averager.sv
// xadc_drp_averager: one DRP read per XADC end-of-conversion on a single channel,
// box-car averaging of 2**LOG2_AVG samples, DRP timeout flag and overrun counter.
module xadc_drp_averager #(
  parameter int         LOG2_AVG = 4,
  parameter logic [4:0] CHANNEL  = 5'h15,
  parameter int         TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic [6:0]  daddr_out,
  output logic        den_out,
  output logic [11:0] avg_out,
  output logic        avg_valid,
  output logic        timeout_err,
  output logic [7:0]  overrun_cnt
);

  localparam int         ACC_W    = 12 + LOG2_AVG;
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [6:0]          r_daddr;
  logic [ACC_W-1:0]    r_acc;
  logic [LOG2_AVG-1:0] r_count;
  logic [7:0]          r_tmo;
  logic [11:0]         r_avg;
  logic                r_timeout_err;
  logic [7:0]          r_overrun;

  logic                w_eoc_hit;
  logic                w_last;
  logic                w_expire;
  logic [ACC_W-1:0]    w_acc_sum;
  logic                w_unused_ok;

  assign w_eoc_hit = eoc_in && (channel_in == CHANNEL);
  assign w_last    = (r_count == {LOG2_AVG{1'b1}});
  // Counter value 1 marks the last cycle a drdy may still be accepted.
  assign w_expire  = (r_tmo <= 8'd1);
  assign w_acc_sum = r_acc + {{LOG2_AVG{1'b0}}, do_in[15:4]};
  // The low nibble of the DRP word carries no conversion data.
  assign w_unused_ok = &{1'b0, do_in[3:0]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_eoc_hit) w_state_next = S_REQ;
      S_REQ:  w_state_next = S_WAIT;
      S_WAIT: begin
        if (drdy_in) begin
          w_state_next = w_last ? S_DONE : S_IDLE;
        end else if (w_expire) begin
          w_state_next = S_IDLE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: address latch, timeout counter, accumulator and average register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_daddr       <= '0;
      r_acc         <= '0;
      r_count       <= '0;
      r_tmo         <= '0;
      r_avg         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_eoc_hit) r_daddr <= {2'b00, channel_in};
        end
        S_REQ: begin
          r_tmo <= TMO_LOAD;
        end
        S_WAIT: begin
          if (drdy_in) begin
            // drdy on the expiry cycle still wins; the sample is kept.
            r_acc   <= w_acc_sum;
            r_count <= r_count + 1'b1;
            if (w_last) r_avg <= w_acc_sum[ACC_W-1:LOG2_AVG];
          end else if (w_expire) begin
            r_tmo         <= '0;
            r_timeout_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo - 8'd1;
          end
        end
        S_DONE: begin
          r_acc   <= '0;
          r_count <= '0;
        end
        default: ;
      endcase
    end
  end

  // Saturating count of matching conversions that arrive while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= '0;
    end else if (w_eoc_hit && (r_state != S_IDLE) && (r_overrun != 8'hFF)) begin
      r_overrun <= r_overrun + 8'd1;
    end
  end

  assign daddr_out   = r_daddr;
  assign den_out     = (r_state == S_REQ);
  assign avg_out     = r_avg;
  assign avg_valid   = (r_state == S_DONE);
  assign timeout_err = r_timeout_err;
  assign overrun_cnt = r_overrun;

endmodule
